relu_layer_scheduler: RTL and testbench
=======================================

Name: relu_layer_scheduler

Overview:
- Sequences a full hidden layer of layer-1 sums through one shared ReLU bank of LANES nodes, one batch at a time.
- Latches all TOTAL_NODES sums on start, drives the bank's sum/trigger inputs per batch, and captures each batch result into an output buffer.
- Presents the completed layer-2 input vector with a valid/ready handshake.
- Sits between the layer-1 accumulator and the layer-2 input stage.

Parameters:
- TOTAL_NODES, 16, neurons in the layer; must be a nonzero multiple of LANES.
- LANES, 4, ReLU nodes in the shared bank.
- IN_W, 16, bit width of one layer-1 sum (two's complement).
- OUT_W, 8, bit width of one ReLU result.
- Derived: NB = TOTAL_NODES/LANES (batch count), BI_W = max(1, clog2(NB)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to process sums_in; sampled only in IDLE.
- sums_in  in  TOTAL_NODES*IN_W  layer-1 sums; node k at bits [k*IN_W +: IN_W].
- busy  out  1  high in every state except IDLE.
- relu_sum_out  out  LANES*IN_W  batch driven to the ReLU bank sumIn.
- relu_trigger  out  1  ReLU bank trigger.
- relu_result_in  in  LANES*OUT_W  ReLU bank layer1Out for the driven batch.
- results  out  TOTAL_NODES*OUT_W  assembled outputs; node k at bits [k*OUT_W +: OUT_W].
- out_valid  out  1  results complete and stable.
- out_ready  in  1  consumer accepts results.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, busy=0, relu_trigger=0, relu_sum_out=0, results=0, out_valid=0, batch index=0, internal sum latch=0.
- Reset asserted in any state, including mid-batch, aborts the operation. No partial results are kept valid.
- States:
  - IDLE: if start=1, latch sums_in, set batch index b=0, go to ISSUE. Otherwise stay.
  - ISSUE: relu_sum_out = latched nodes [b*LANES, b*LANES+LANES-1]; relu_trigger=1. Go to CAPTURE.
  - CAPTURE: relu_sum_out held; relu_trigger=0. At the edge leaving CAPTURE, write relu_result_in into results nodes [b*LANES .. b*LANES+LANES-1].
    - If b==NB-1: go to DONE.
    - Else: b=b+1, go to ISSUE.
  - DONE: out_valid=1 and results frozen. When out_ready=1 at an edge: out_valid=0, go to IDLE. results keep their value until the next capture.
- Latency:
  - Start-sampling edge = edge 0. out_valid rises after edge 2*NB (edge 8 for the defaults).
  - From DONE, the earliest new start is sampled one cycle after the handshake edge.
- Handshake: out_valid never drops without out_ready. out_ready while out_valid=0 is ignored.
- start while busy=1 (ISSUE, CAPTURE or DONE) is ignored, not queued.
- sums_in may change freely after the start edge; only the latched copy is used.
- results nodes not yet written in the current pass hold their previous-pass values. Only DONE guarantees consistency.
- The scheduler does no arithmetic on data: sign/clipping is entirely the ReLU bank's.
- NB=1 is legal: the sequence is ISSUE, CAPTURE, DONE.

Optional Feature:
- Macro: RELU_ZERO_COUNT_EN.
- Defined:
  - Adds output port zero_count, width clog2(TOTAL_NODES+1).
  - Cleared on reset and on the start-sampling edge.
  - Each CAPTURE edge adds the number of lanes whose relu_result_in slice is all zero.
  - Value is final and stable while out_valid=1, and holds until the next start.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Bench ReLU model: result = sum negative ? 0 : sum[OUT_W-1:0]. sums_in node k = k-8, i.e. -8..7, so results nodes 0..8 = 0 and nodes 9..15 = 1..7.
  - Pulse start, hold out_ready=0: relu_trigger pulses exactly 4 times, two cycles apart; out_valid rises after edge 8.
  - out_valid stays high for 5 extra cycles; raising out_ready gives out_valid=0 and busy=0 next cycle.
  - With RELU_ZERO_COUNT_EN: zero_count = 9.
- start re-asserted during CAPTURE of batch 1 -> ignored; exactly 4 triggers; one out_valid. Changing sums_in after the start edge has no effect on results.
- Assert reset for 1 cycle during ISSUE of batch 2 -> next cycle IDLE, busy=0, results=0, out_valid=0, relu_trigger=0. A following start with all sums = 5 yields all results = 5.
- out_ready held high before start -> out_valid high exactly 1 cycle after edge 8. A start asserted in that same cycle is ignored; a start held one further cycle is accepted (back-to-back run).
- Instance with TOTAL_NODES=4, LANES=4 (NB=1), sums 100,-1,0,-32768 -> one trigger; results 100,0,0,0; out_valid after edge 2; with RELU_ZERO_COUNT_EN, zero_count=3.

Source files
------------

// File: rtl/relu_layer_scheduler.sv
// Time-multiplexes a hidden layer of layer-1 sums through a shared LANES-wide ReLU bank.
// Optional macro RELU_ZERO_COUNT_EN adds a zero_count output tallying all-zero results.
module relu_layer_scheduler #(
   parameter int TOTAL_NODES = 16,
   parameter int LANES       = 4,
   parameter int IN_W        = 16,
   parameter int OUT_W       = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [TOTAL_NODES*IN_W-1:0]    sums_in,
   output logic                           busy,
   output logic [LANES*IN_W-1:0]          relu_sum_out,
   output logic                           relu_trigger,
   input  logic [LANES*OUT_W-1:0]         relu_result_in,
   output logic [TOTAL_NODES*OUT_W-1:0]   results,
   output logic                           out_valid,
   input  logic                           out_ready
`ifdef RELU_ZERO_COUNT_EN
   ,
   output logic [$clog2(TOTAL_NODES+1)-1:0] zero_count
`endif
);

   localparam int NB    = TOTAL_NODES / LANES;
   localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int SUM_W = LANES * IN_W;
   localparam int RES_W = LANES * OUT_W;
   localparam logic [BI_W-1:0] LAST_BATCH = BI_W'(NB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                         r_state;
   state_t                         w_nextState;
   logic [BI_W-1:0]                r_batch;
   logic [BI_W-1:0]                w_batchNext;
   logic                           w_lastBatch;
   logic [TOTAL_NODES*IN_W-1:0]    r_sumLatch;
   logic [SUM_W-1:0]               r_sumOut;
   logic [TOTAL_NODES*OUT_W-1:0]   r_results;
   logic                           r_busy;
   logic                           r_trigger;
   logic                           r_valid;

   assign w_batchNext  = r_batch + BI_W'(1);
   assign w_lastBatch  = (r_batch == LAST_BATCH);
   assign busy         = r_busy;
   assign relu_sum_out = r_sumOut;
   assign relu_trigger = r_trigger;
   assign results      = r_results;
   assign out_valid    = r_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:    if (start) w_nextState = S_ISSUE;
         S_ISSUE:   w_nextState = S_CAPTURE;
         S_CAPTURE: w_nextState = w_lastBatch ? S_DONE : S_ISSUE;
         S_DONE:    if (out_ready) w_nextState = S_IDLE;
         default:   w_nextState = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy     <= 1'b0;
         r_trigger  <= 1'b0;
         r_valid    <= 1'b0;
         r_batch    <= '0;
         r_sumLatch <= '0;
         r_sumOut   <= '0;
         r_results  <= '0;
      end else begin
         r_busy    <= (w_nextState != S_IDLE);
         r_trigger <= (w_nextState == S_ISSUE);
         r_valid   <= (w_nextState == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sumLatch <= sums_in;
                  r_batch    <= '0;
                  r_sumOut   <= sums_in[SUM_W-1:0];
               end
            end
            S_CAPTURE: begin
               r_results[int'(r_batch)*RES_W +: RES_W] <= relu_result_in;
               if (!w_lastBatch) begin
                  r_batch  <= w_batchNext;
                  r_sumOut <= r_sumLatch[int'(w_batchNext)*SUM_W +: SUM_W];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RELU_ZERO_COUNT_EN
   localparam int ZC_W = $clog2(TOTAL_NODES + 1);

   logic [ZC_W-1:0] r_zeroCount;
   logic [ZC_W-1:0] w_zeroLanes;

   assign zero_count = r_zeroCount;

   always_comb begin
      w_zeroLanes = '0;
      for (int l = 0; l < LANES; l++) begin
         if (relu_result_in[l*OUT_W +: OUT_W] == '0) w_zeroLanes = w_zeroLanes + ZC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_zeroCount <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_zeroCount <= '0;
      end else if (r_state == S_CAPTURE) begin
         r_zeroCount <= r_zeroCount + w_zeroLanes;
      end
   end
`endif

endmodule

// File: tb/tb_relu_layer_scheduler.sv
// Directed bench for relu_layer_scheduler: a 16-node/4-lane instance and a single-batch 4/4 instance.
module tb_relu_layer_scheduler;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [255:0]  sumsIn;
   logic          busy;
   logic [63:0]   reluSumOut;
   logic          reluTrigger;
   logic [31:0]   reluResult;
   logic [127:0]  results;
   logic          outValid;
   logic          outReady;

   logic          start1;
   logic [63:0]   sums1;
   logic          busy1;
   logic [63:0]   reluSumOut1;
   logic          reluTrigger1;
   logic [31:0]   reluResult1;
   logic [31:0]   results1;
   logic          outValid1;
   logic          outReady1;

`ifdef RELU_ZERO_COUNT_EN
   logic [4:0]    zeroCount;
   logic [2:0]    zeroCount1;
`endif

   int checkCount = 0;
   int errorCount = 0;

   logic [255:0]  patA, patB, patFive;
   logic [127:0]  expA, expB, expFive;

   always #5 clk = ~clk;

   relu_layer_scheduler #(.TOTAL_NODES(16), .LANES(4), .IN_W(16), .OUT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .sums_in(sumsIn), .busy(busy),
      .relu_sum_out(reluSumOut), .relu_trigger(reluTrigger), .relu_result_in(reluResult),
      .results(results), .out_valid(outValid), .out_ready(outReady)
`ifdef RELU_ZERO_COUNT_EN
      , .zero_count(zeroCount)
`endif
   );

   relu_layer_scheduler #(.TOTAL_NODES(4), .LANES(4), .IN_W(16), .OUT_W(8)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .sums_in(sums1), .busy(busy1),
      .relu_sum_out(reluSumOut1), .relu_trigger(reluTrigger1), .relu_result_in(reluResult1),
      .results(results1), .out_valid(outValid1), .out_ready(outReady1)
`ifdef RELU_ZERO_COUNT_EN
      , .zero_count(zeroCount1)
`endif
   );

   // Behavioural ReLU banks: negative sums clip to zero, others keep their low OUT_W bits.
   always_comb begin
      reluResult  = '0;
      reluResult1 = '0;
      for (int l = 0; l < 4; l++) begin
         reluResult[l*8 +: 8]  = reluSumOut[l*16 + 15]  ? 8'd0 : reluSumOut[l*16 +: 8];
         reluResult1[l*8 +: 8] = reluSumOut1[l*16 + 15] ? 8'd0 : reluSumOut1[l*16 +: 8];
      end
   end

   function automatic logic [127:0] reluModel(input logic [255:0] s);
      logic [127:0] r;
      logic [15:0]  v;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         v = s[k*16 +: 16];
         r[k*8 +: 8] = v[15] ? 8'd0 : v[7:0];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic startVal, input logic [255:0] sums, input logic ready);
      start    = startVal;
      sumsIn   = sums;
      outReady = ready;
   endtask

   // Called at the falling edge after edge c of a 16-node pass started at edge 0.
   task automatic checkCycle(input string name, input int c, input logic [255:0] pat);
      logic expTrig;
      expTrig = (c % 2 == 0) && (c < 8);
      checkOutput($sformatf("%s_trig_c%0d", name, c), 128'(reluTrigger), 128'(expTrig));
      checkOutput($sformatf("%s_valid_c%0d", name, c), 128'(outValid), 128'(c == 8));
      checkOutput($sformatf("%s_busy_c%0d", name, c), 128'(busy), 128'd1);
      if (expTrig) checkOutput($sformatf("%s_sumout_c%0d", name, c), 128'(reluSumOut), 128'(pat[(c/2)*64 +: 64]));
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         patA[k*16 +: 16]    = 16'(k - 8);
         patB[k*16 +: 16]    = 16'(7 - k);
         patFive[k*16 +: 16] = 16'd5;
      end
      expA    = reluModel(patA);
      expB    = reluModel(patB);
      expFive = {16{8'd5}};

      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      start1 = 1'b0; sums1 = '0; outReady1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      checkOutput("rst_busy", 128'(busy), 128'd0);
      checkOutput("rst_trig", 128'(reluTrigger), 128'd0);
      checkOutput("rst_sumout", 128'(reluSumOut), 128'd0);
      checkOutput("rst_results", results, 128'd0);
      checkOutput("rst_valid", 128'(outValid), 128'd0);

      // Pass A: basic run, out_ready held low, then a late handshake.
      applyStimulus(1'b1, patA, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         checkCycle("passA", c, patA);
      end
      checkOutput("passA_results", results, expA);
      checkOutput("passA_node8", 128'(results[8*8 +: 8]), 128'd0);
      checkOutput("passA_node9", 128'(results[9*8 +: 8]), 128'd1);
      checkOutput("passA_node15", 128'(results[15*8 +: 8]), 128'd7);
`ifdef RELU_ZERO_COUNT_EN
      checkOutput("passA_zero_count", 128'(zeroCount), 128'd9);
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("passA_hold_valid%0d", i), 128'(outValid), 128'd1);
         checkOutput($sformatf("passA_hold_res%0d", i), results, expA);
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("passA_hs_valid", 128'(outValid), 128'd0);
      checkOutput("passA_hs_busy", 128'(busy), 128'd0);
      checkOutput("passA_hs_results", results, expA);

      // Pass B: start during CAPTURE of batch 1 and sums_in changed after the start edge.
      applyStimulus(1'b1, patB, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         if (c == 1) sumsIn = patA;
         if (c == 3) start = 1'b1;
         if (c == 4) start = 1'b0;
         checkCycle("passB", c, patB);
      end
      checkOutput("passB_results", results, expB);
`ifdef RELU_ZERO_COUNT_EN
      checkOutput("passB_zero_count", 128'(zeroCount), 128'd9);
`endif
      @(negedge clk);
      checkOutput("passB_valid_holds", 128'(outValid), 128'd1);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("passB_hs_busy", 128'(busy), 128'd0);

      // Reset during ISSUE of batch 2 aborts the pass.
      applyStimulus(1'b1, patA, 1'b0);
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         checkCycle("abort", c, patA);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_busy", 128'(busy), 128'd0);
      checkOutput("abort_results", results, 128'd0);
      checkOutput("abort_valid", 128'(outValid), 128'd0);
      checkOutput("abort_trig", 128'(reluTrigger), 128'd0);
      applyStimulus(1'b1, patFive, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         checkCycle("five", c, patFive);
      end
      checkOutput("five_results", results, expFive);
`ifdef RELU_ZERO_COUNT_EN
      checkOutput("five_zero_count", 128'(zeroCount), 128'd0);
`endif
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;

      // out_ready held high: one-cycle out_valid, then back-to-back start.
      applyStimulus(1'b1, patB, 1'b1);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         checkCycle("b2b", c, patB);
      end
      checkOutput("b2b_results", results, expB);
      start = 1'b1;
      sumsIn = patA;
      @(negedge clk);
      checkOutput("b2b_e9_valid", 128'(outValid), 128'd0);
      checkOutput("b2b_e9_busy", 128'(busy), 128'd0);
      checkOutput("b2b_e9_trig", 128'(reluTrigger), 128'd0);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         checkCycle("b2b2", c, patA);
      end
      checkOutput("b2b2_results", results, expA);
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("b2b2_end_valid", 128'(outValid), 128'd0);
      checkOutput("b2b2_end_busy", 128'(busy), 128'd0);

      // Single-batch instance.
      start1 = 1'b1;
      sums1  = {16'h8000, 16'h0000, 16'hFFFF, 16'd100};
      @(negedge clk);
      start1 = 1'b0;
      checkOutput("nb1_c0_trig", 128'(reluTrigger1), 128'd1);
      checkOutput("nb1_c0_busy", 128'(busy1), 128'd1);
      checkOutput("nb1_c0_sumout", 128'(reluSumOut1), 128'({16'h8000, 16'h0000, 16'hFFFF, 16'd100}));
      @(negedge clk);
      checkOutput("nb1_c1_trig", 128'(reluTrigger1), 128'd0);
      checkOutput("nb1_c1_valid", 128'(outValid1), 128'd0);
      @(negedge clk);
      checkOutput("nb1_c2_trig", 128'(reluTrigger1), 128'd0);
      checkOutput("nb1_c2_valid", 128'(outValid1), 128'd1);
      checkOutput("nb1_results", 128'(results1), 128'({8'd0, 8'd0, 8'd0, 8'd100}));
`ifdef RELU_ZERO_COUNT_EN
      checkOutput("nb1_zero_count", 128'(zeroCount1), 128'd3);
`endif
      @(negedge clk);
      checkOutput("nb1_c3_valid_holds", 128'(outValid1), 128'd1);
      outReady1 = 1'b1;
      @(negedge clk);
      outReady1 = 1'b0;
      checkOutput("nb1_hs_valid", 128'(outValid1), 128'd0);
      checkOutput("nb1_hs_busy", 128'(busy1), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
